// File: rtl/sync_fifo.sv
// Single-clock FIFO with a direct fill counter, registered or fall-through read,
// almost-full/almost-empty flags, a fill-level output and one-cycle error pulses.
module sync_fifo #(
  parameter int DSIZE        = 8,
  parameter int ASIZE        = 4,
  parameter int FWFT         = 0,
  parameter int AFULL_LEVEL  = 12,
  parameter int AEMPTY_LEVEL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             awfull,
  output logic             wr_err,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             arempty,
  output logic             rd_err,
  output logic [ASIZE:0]   level
);

  localparam int DEPTH = 1 << ASIZE;
  localparam int LW    = ASIZE + 1;

  localparam logic [LW-1:0]    DepthLvl  = LW'(DEPTH);
  localparam logic [LW-1:0]    AfullLvl  = LW'(AFULL_LEVEL);
  localparam logic [LW-1:0]    AemptyLvl = LW'(AEMPTY_LEVEL);
  localparam logic [LW-1:0]    LvlOne    = LW'(1);
  localparam logic [ASIZE-1:0] PtrOne    = ASIZE'(1);

  logic [DSIZE-1:0] mem [DEPTH];

  logic [ASIZE-1:0] wrPtr_q, wrPtr_d;
  logic [ASIZE-1:0] rdPtr_q, rdPtr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             wfull_q, wfull_d;
  logic             awfull_q, awfull_d;
  logic             rempty_q, rempty_d;
  logic             arempty_q, arempty_d;
  logic             wrErr_q, wrErr_d;
  logic             rdErr_q, rdErr_d;

  logic wrAcc;
  logic rdAcc;

  // Acceptance is qualified only by the current registered flags, so a pop in the
  // same cycle never makes room for a write to a full FIFO (and vice versa).
  always_comb begin
    wrAcc = winc && !wfull_q;
    rdAcc = rinc && !rempty_q;
  end

  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    level_d   = level_q;
    wrErr_d   = winc && wfull_q;
    rdErr_d   = rinc && rempty_q;

    if (wrAcc) begin
      wrPtr_d = wrPtr_q + PtrOne;
    end
    if (rdAcc) begin
      rdPtr_d = rdPtr_q + PtrOne;
    end

    if (wrAcc && !rdAcc) begin
      level_d = level_q + LvlOne;
    end else if (rdAcc && !wrAcc) begin
      level_d = level_q - LvlOne;
    end

    // Flags come from the next level so they agree with level after every edge.
    rempty_d  = (level_d == '0);
    wfull_d   = (level_d == DepthLvl);
    awfull_d  = (level_d >= AfullLvl);
    arempty_d = (level_d <= AemptyLvl);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      level_q   <= '0;
      wfull_q   <= 1'b0;
      awfull_q  <= 1'b0;
      rempty_q  <= 1'b1;
      arempty_q <= 1'b1;
      wrErr_q   <= 1'b0;
      rdErr_q   <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      level_q   <= level_d;
      wfull_q   <= wfull_d;
      awfull_q  <= awfull_d;
      rempty_q  <= rempty_d;
      arempty_q <= arempty_d;
      wrErr_q   <= wrErr_d;
      rdErr_q   <= rdErr_d;
    end
  end

  // Storage is deliberately not reset; clearing the pointers and level is enough.
  always_ff @(posedge clk) begin
    if (wrAcc) begin
      mem[wrPtr_q] <= wdata;
    end
  end

  generate
    if (FWFT != 0) begin : gFwft
      assign rdata = mem[rdPtr_q];
    end else begin : gRegRead
      logic [DSIZE-1:0] rdata_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata_q <= '0;
        end else if (rdAcc) begin
          rdata_q <= mem[rdPtr_q];
        end
      end

      assign rdata = rdata_q;
    end
  endgenerate

  assign wfull   = wfull_q;
  assign awfull  = awfull_q;
  assign wr_err  = wrErr_q;
  assign rempty  = rempty_q;
  assign arempty = arempty_q;
  assign rd_err  = rdErr_q;
  assign level   = level_q;

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO: the same-clock successor to the dual-clock FIFO. It replaces gray-pointer synchronisation with a direct fill counter and adds selectable read mode (registered or first-word-fall-through), programmable almost-full/almost-empty flags, a fill-level output and error pulses. It sits between producer and consumer logic that share one clock domain.

## Interface
- DSIZE, 8, data width in bits
- ASIZE, 4, address width; DEPTH = 2**ASIZE words
- FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through
- AFULL_LEVEL, 12, awfull asserted when level >= AFULL_LEVEL; legal 1..DEPTH
- AEMPTY_LEVEL, 3, arempty asserted when level <= AEMPTY_LEVEL; legal 0..DEPTH-1

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- winc  in  1  write request
- wdata  in  DSIZE  write data
- wfull  out  1  FIFO holds DEPTH words
- awfull  out  1  almost full
- wr_err  out  1  one-cycle pulse: winc while wfull, write dropped
- rinc  in  1  read request (pop)
- rdata  out  DSIZE  read data
- rempty  out  1  FIFO holds 0 words
- arempty  out  1  almost empty
- rd_err  out  1  one-cycle pulse: rinc while rempty, read ignored
- level  out  ASIZE+1  words currently held, 0..DEPTH

## Operation
- Write accepted iff winc && !wfull: mem[waddr] <= wdata, waddr increments modulo DEPTH.
- Read accepted iff rinc && !rempty: raddr increments modulo DEPTH.
- Pointers are ASIZE bits and wrap naturally; fullness comes only from level, never from pointer compare.
- level next = level + wr_acc - rd_acc; simultaneous accepted read and write leaves level unchanged.
- Write while full is rejected even when a read occurs in the same cycle (wfull is the sole qualifier); wr_err pulses.
- Read while empty is rejected even when a write occurs in the same cycle; rd_err pulses.
- FWFT=0: rdata is a register loaded with mem[raddr] on an accepted read; it holds its value otherwise.
- FWFT=1: rdata = mem[raddr] combinationally; it is valid whenever rempty=0 and don't-care while rempty=1. rinc acknowledges and pops the presented word.
- Flags are registered, computed from next level: rempty = (level==0), wfull = (level==DEPTH), awfull = (level>=AFULL_LEVEL), arempty = (level<=AEMPTY_LEVEL).
- Storage array is not reset; all contents are lost logically on reset.
- Reset values: level=0, rempty=1, arempty=1, wfull=0, awfull=0, wr_err=0, rd_err=0, rdata=0 (FWFT=0 register); pointers=0.
- Reset asserted mid-operation clears all state immediately (asynchronous). Deassertion is synchronised externally; the first edge after release may accept a write.

## Timing
- Write at edge N: level, rempty, arempty, wfull and awfull reflect it after edge N (0-cycle flag latency).
- FWFT=1: a word written into an empty FIFO at edge N appears on rdata after edge N and can be popped at edge N+1.
- FWFT=0: read accepted at edge N puts the word on rdata after edge N; earliest read of a word written at edge N is at edge N+1, with data after edge N+1.
- wr_err and rd_err are registered and assert for exactly one cycle after the offending edge. Back-to-back errors give back-to-back pulses.
- Throughput: one write and one read per cycle sustained, including at the wrap point.

## Test plan
- Reset: assert rst with no clock -> level=0, rempty=1, arempty=1, wfull=0, awfull=0, rdata=0, immediately.
- Fill: write 0x00..0x0F on 16 consecutive edges -> awfull rises after 12th write, arempty falls after 4th write, wfull=1 and level=16 after 16th. A 17th winc -> wr_err pulses 1 cycle, level stays 16.
- Drain, FWFT=0: from full, rinc on 16 edges -> rdata = 0x00..0x0F, each one cycle after its read edge. rempty=1 after 16th read. Extra rinc -> rd_err pulse, rdata holds 0x0F.
- FWFT=1: write 0xA5 into empty FIFO -> rdata=0xA5 and rempty=0 after that edge. rinc next edge -> rempty=1.
- Simultaneous: at level=16, winc+rinc -> read accepted, write dropped, wr_err=1, level=15. At level=5, winc+rinc for 40 cycles across pointer wrap -> level stays 5, data order preserved.
- Mid-operation reset: at level=9, pulse rst between edges -> all outputs at reset values at once. Then write 0x3C and read -> 0x3C returned.
